// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 matrix keypad scanner with frame-based press/release debounce
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic       multi_key
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] DB       = 4'(DEBOUNCE_SCANS);

  logic [3:0]  sync1_q, sync2_q;
  logic [7:0]  div_q, div_d;
  logic [1:0]  col_q, col_d;
  logic [11:0] seen_q, seen_d;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  code_q, code_d;
  logic        strobe_q, strobe_d;
  logic        multi_q, multi_d;

  logic        sample, frame_end;
  logic [11:0] col_bits, frame_keys;
  logic [3:0]  n_keys, hit_code, cnt_inc;
  logic        res_key, res_multi, match;

  // Key index is row*3+col; bus code is digit+1, '*'=11, '#'=12.
  function automatic logic [3:0] code_of(input int idx);
    case (idx)
      9:       code_of = 4'd11;
      10:      code_of = 4'd1;
      11:      code_of = 4'd12;
      default: code_of = 4'(idx + 2);
    endcase
  endfunction

  always_comb begin
    sample    = (div_q == DIV_LAST);
    frame_end = sample && (col_q == 2'd2);
    col_bits  = '0;
    for (int r = 0; r < 4; r++) begin
      col_bits[r*3 + int'(col_q)] = ~sync2_q[r];
    end
    frame_keys = seen_q | col_bits;
    n_keys   = '0;
    hit_code = '0;
    for (int i = 0; i < 12; i++) begin
      if (frame_keys[i]) begin
        n_keys   = n_keys + 4'd1;
        hit_code = code_of(i);
      end
    end
    res_key   = (n_keys == 4'd1);
    res_multi = (n_keys > 4'd1);
    match     = res_key && (hit_code == cand_q);
    cnt_inc   = cnt_q + 4'd1;
  end

  always_comb begin
    div_d  = sample ? 8'd0 : div_q + 8'd1;
    col_d  = col_q;
    seen_d = seen_q;
    if (sample) begin
      col_d  = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
      seen_d = frame_end ? 12'd0 : frame_keys;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    code_d   = code_q;
    strobe_d = 1'b0;
    multi_d  = multi_q;
    if (frame_end) begin
      multi_d = res_multi;
      case (state_q)
        IDLE: begin
          if (res_key) begin
            cand_d = hit_code;
            cnt_d  = 4'd1;
            if (DB == 4'd1) begin
              state_d  = HELD;
              code_d   = hit_code;
              strobe_d = 1'b1;
            end else begin
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (match) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB) begin
              state_d  = HELD;
              code_d   = cand_q;
              strobe_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        HELD: begin
          if (!match) begin
            cnt_d = 4'd1;
            if (DB == 4'd1) begin
              state_d = IDLE;
              code_d  = 4'd0;
            end else begin
              state_d = REL_DB;
            end
          end
        end
        default: begin
          if (match) begin
            state_d = HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB) begin
              state_d = IDLE;
              code_d  = 4'd0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 4'b1111;
      sync2_q  <= 4'b1111;
      div_q    <= '0;
      col_q    <= '0;
      seen_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      code_q   <= '0;
      strobe_q <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      sync1_q  <= row_n;
      sync2_q  <= sync1_q;
      div_q    <= div_d;
      col_q    <= col_d;
      seen_q   <= seen_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      multi_q  <= multi_d;
    end
  end

  always_comb begin
    case (col_q)
      2'd0:    col_n = 3'b110;
      2'd1:    col_n = 3'b101;
      default: col_n = 3'b011;
    endcase
  end

  assign key_code   = code_q;
  assign key_strobe = strobe_q;
  assign multi_key  = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with a key_code transition scoreboard
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [3:0]  key_code;
  logic        key_strobe;
  logic        multi_key;

  logic [11:0] keys = '0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          strobe_cnt = 0;
  int          exp_strobes = 0;
  logic        mon_en = 1'b0;
  logic [3:0]  prev_code = '0;
  logic [3:0]  exp_q[$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_strobe(key_strobe), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!col_n[c] && keys[r*3+c]) row_n[r] = 1'b0;
  end

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every key_code change must match the next scoreboard entry and land on a frame end.
  always @(negedge clk) begin
    if (mon_en) begin
      if (key_code !== prev_code) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_change", {28'd0, key_code}, {28'd0, prev_code});
        end else begin
          chk("sb_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
        end
        chk("change_on_frame_end", cyc % 12, 0);
        chk("strobe_with_change", key_strobe, key_code != 4'd0);
        prev_code = key_code;
      end else if (key_strobe) begin
        chk("stray_strobe", key_strobe, 1'b0);
      end
      if (key_strobe) strobe_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align();
    while (cyc % 12 != 0) @(negedge clk);
  endtask

  initial begin
    #3 reset = 1'b1;
    step(3);
    chk("rst_key_code", key_code, 4'd0);
    chk("rst_strobe", key_strobe, 1'b0);
    chk("rst_multi", multi_key, 1'b0);
    chk("rst_col", col_n, 3'b110);
    reset = 1'b0;
    mon_en = 1'b1;
    chk("col0", col_n, 3'b110);
    step(4); chk("col1", col_n, 3'b101);
    step(4); chk("col2", col_n, 3'b011);
    step(4); chk("col_wrap", col_n, 3'b110);

    // '5' held only two frames must be rejected
    align(); keys[4] = 1'b1;
    step(24); keys[4] = 1'b0;
    step(48);
    chk("short_press_code", key_code, 4'd0);
    chk("short_press_strobes", strobe_cnt, exp_strobes);

    // clean '5'
    align(); exp_q.push_back(4'd6); keys[4] = 1'b1;
    step(35); chk("p5_before", key_code, 4'd0);
    step(1);  chk("p5_code", key_code, 4'd6); chk("p5_strobe", key_strobe, 1'b1);
    exp_strobes++;
    step(1);  chk("p5_strobe_low", key_strobe, 1'b0);
    step(71); exp_q.push_back(4'd0); keys[4] = 1'b0;
    step(35); chk("r5_before", key_code, 4'd6);
    step(1);  chk("r5_code", key_code, 4'd0);
    chk("p5_strobes", strobe_cnt, exp_strobes);

    // bouncy '0'
    align(); exp_q.push_back(4'd1);
    for (int i = 0; i < 8; i++) begin
      keys[10] = ~keys[10];
      step(5);
    end
    keys[10] = 1'b1;
    chk("bounce_no_strobe", strobe_cnt, exp_strobes);
    step(36);
    chk("bounce_code", key_code, 4'd1);
    exp_strobes++;
    chk("bounce_strobes", strobe_cnt, exp_strobes);
    exp_q.push_back(4'd0); keys[10] = 1'b0;
    step(48); chk("bounce_rel", key_code, 4'd0);

    // '1' and '2' together, then '2' released
    align(); keys[0] = 1'b1; keys[1] = 1'b1;
    step(12); chk("multi_set", multi_key, 1'b1);
    step(108);
    chk("multi_hold", multi_key, 1'b1);
    chk("multi_code", key_code, 4'd0);
    chk("multi_strobes", strobe_cnt, exp_strobes);
    exp_q.push_back(4'd2); keys[1] = 1'b0;
    step(12); chk("multi_clear", multi_key, 1'b0);
    step(23); chk("p1_before", key_code, 4'd0);
    step(1);  chk("p1_code", key_code, 4'd2); chk("p1_strobe", key_strobe, 1'b1);
    exp_strobes++;
    exp_q.push_back(4'd0); keys[0] = 1'b0;
    step(48); chk("p1_rel", key_code, 4'd0);

    // '#' with a one-frame dropout
    align(); exp_q.push_back(4'd12); keys[11] = 1'b1;
    step(36); chk("hash_code", key_code, 4'd12);
    exp_strobes++;
    keys[11] = 1'b0; step(12);
    chk("hash_dropout", key_code, 4'd12);
    keys[11] = 1'b1; step(48);
    chk("hash_held", key_code, 4'd12);
    chk("hash_strobes", strobe_cnt, exp_strobes);
    exp_q.push_back(4'd0); keys[11] = 1'b0;
    step(35); chk("hash_rel_before", key_code, 4'd12);
    step(1);  chk("hash_rel", key_code, 4'd0);

    // reset while '7' is held
    align(); exp_q.push_back(4'd8); keys[6] = 1'b1;
    step(36); chk("p7_code", key_code, 4'd8);
    exp_strobes++;
    exp_q.push_back(4'd0);
    #2 reset = 1'b1;
    #1 chk("p7_async_clear", key_code, 4'd0);
    chk("p7_rst_col", col_n, 3'b110);
    step(2);
    reset = 1'b0;
    exp_q.push_back(4'd8);
    step(35); chk("p7_re_before", key_code, 4'd0);
    step(1);  chk("p7_re_code", key_code, 4'd8); chk("p7_re_strobe", key_strobe, 1'b1);
    exp_strobes++;
    exp_q.push_back(4'd0); keys[6] = 1'b0;
    step(48); chk("p7_rel", key_code, 4'd0);
    chk("total_strobes", strobe_cnt, exp_strobes);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
